i2s_dac_serializer: RTL and testbench

Downstream consumer of the 16-bit audio sample register driven by the Nios II PIO (`out_port`).
- Generates the codec serial clocks (BCLK, DACLRCK) from the system clock.
- Latches one sample per frame into a shadow register, so a CPU write during a frame never tears the output.
- Shifts the sample MSB-first onto DACDAT in I2S format, in both channel slots (mono playback).

---
 rtl/i2s_dac_serializer.sv | 94 +++++++++
 tb/tb_i2s_dac_serializer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_serializer.sv
// rtl/i2s_dac_serializer.sv - I2S mono DAC serializer with per-frame shadowed sample.
// Optional macro I2S_LEFT_JUSTIFY_EN selects left-justified instead of I2S slot alignment.
module i2s_dac_serializer #(
  parameter int DATA_W    = 16,
  parameter int BCLK_HALF = 8,
  parameter int SLOT_BITS = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample_in,
  output logic              aud_bclk,
  output logic              aud_daclrck,
  output logic              aud_dacdat,
  output logic              sample_taken
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_C  = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] DW_C    = BIT_W'(DATA_W);

  logic [DIV_W-1:0]  r_div_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shadow;
  logic              r_bclk;
  logic              r_lrck;
  logic              r_dat;
  logic              r_taken;

  logic              w_tick;
  logic              w_fall;
  logic              w_wrap;
  logic [BIT_W-1:0]  w_bit_next;
  logic [BIT_W-1:0]  w_pos;
  logic [BIT_W-1:0]  w_shift;
  logic [DATA_W-1:0] w_shadow_next;
  logic              w_in_win;
  logic              w_dat_next;

  always_comb begin
    w_tick        = (r_div_cnt == DIV_MAX);
    w_fall        = w_tick && r_bclk;
    w_wrap        = (r_bit_cnt == BIT_MAX);
    w_bit_next    = w_wrap ? '0 : r_bit_cnt + 1'b1;
    // New frame data is visible on the very falling edge that latches it.
    w_shadow_next = w_wrap ? sample_in : r_shadow;
    w_pos         = (w_bit_next >= SLOT_C) ? w_bit_next - SLOT_C : w_bit_next;
`ifdef I2S_LEFT_JUSTIFY_EN
    w_in_win      = (w_pos < DW_C);
    w_shift       = DW_C - BIT_W'(1) - w_pos;
`else
    w_in_win      = (w_pos != '0) && (w_pos <= DW_C);
    w_shift       = DW_C - w_pos;
`endif
    w_dat_next    = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (w_in_win && (w_shift == BIT_W'(i))) begin
        w_dat_next = w_shadow_next[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shadow  <= '0;
      r_bclk    <= 1'b0;
      r_lrck    <= 1'b0;
      r_dat     <= 1'b0;
      r_taken   <= 1'b0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      if (w_tick) begin
        r_bclk <= ~r_bclk;
      end
      r_taken <= w_fall && w_wrap;
      if (w_fall) begin
        r_bit_cnt <= w_bit_next;
        r_shadow  <= w_shadow_next;
        r_lrck    <= (w_bit_next >= SLOT_C);
        r_dat     <= w_dat_next;
      end
    end
  end

  assign aud_bclk     = r_bclk;
  assign aud_daclrck  = r_lrck;
  assign aud_dacdat   = r_dat;
  assign sample_taken = r_taken;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// tb/tb_i2s_dac_serializer.sv - self-checking bench for i2s_dac_serializer.
module tb_i2s_dac_serializer;
  localparam int DW    = 16;
  localparam int HALF  = 8;
  localparam int SLOT  = 32;
  localparam int FRAME = 2 * SLOT * 2 * HALF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] sample_in = 16'h7FFF;
  logic          aud_bclk, aud_daclrck, aud_dacdat, sample_taken;

  int n_checks = 0;
  int n_fail   = 0;

  i2s_dac_serializer #(.DATA_W(DW), .BCLK_HALF(HALF), .SLOT_BITS(SLOT)) dut (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in),
    .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
    .aud_dacdat(aud_dacdat), .sample_taken(sample_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: everything follows from clocks elapsed since reset release.
  int            m_t = 0;
  logic [DW-1:0] m_shadow = '0;
  bit            m_valid = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_t      <= 0;
      m_shadow <= '0;
      m_valid  <= 1'b1;
    end else begin
      m_t <= m_t + 1;
      if ((m_t + 1) % FRAME == 0) m_shadow <= sample_in;
    end
  end

  function automatic logic [3:0] predict(input int t, input logic [DW-1:0] sh);
    int   bitc;
    int   p;
    logic d;
    bitc = (t / (2 * HALF)) % (2 * SLOT);
    p    = bitc % SLOT;
    d    = 1'b0;
`ifdef I2S_LEFT_JUSTIFY_EN
    if (p <= DW - 1) d = sh[DW-1-p];
`else
    if (p >= 1 && p <= DW) d = sh[DW-p];
`endif
    return {((t / HALF) % 2) == 1, bitc >= SLOT, d, (t > 0) && (t % FRAME == 0)};
  endfunction

  logic       p_bclk, p_lrck, p_dat;
  bit         p_ok = 1'b0;
  bit         have_taken = 1'b0;
  int         cyc = 0, last_taken = 0, lo = 0, hi = 0;
  logic [3:0] exp_o;

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      exp_o = predict(m_t, m_shadow);
      check("model_bclk",  {31'b0, aud_bclk},     {31'b0, exp_o[3]});
      check("model_lrck",  {31'b0, aud_daclrck},  {31'b0, exp_o[2]});
      check("model_dat",   {31'b0, aud_dacdat},   {31'b0, exp_o[1]});
      check("model_taken", {31'b0, sample_taken}, {31'b0, exp_o[0]});
      if (!reset_n) begin
        p_ok       = 1'b0;
        have_taken = 1'b0;
      end else begin
        if (p_ok && (aud_dacdat !== p_dat || aud_daclrck !== p_lrck))
          check("edge_align", {30'b0, p_bclk, aud_bclk}, 32'd2);
        if (sample_taken) begin
          if (have_taken) begin
            check("taken_period", cyc - last_taken, FRAME);
            check("lrck_low",  lo, FRAME / 2);
            check("lrck_high", hi, FRAME / 2);
          end
          have_taken = 1'b1;
          last_taken = cyc;
          lo = 0;
          hi = 0;
        end
        if (aud_daclrck) hi++; else lo++;
        p_ok = 1'b1;
      end
      p_bclk = aud_bclk;
      p_lrck = aud_daclrck;
      p_dat  = aud_dacdat;
    end
    cyc++;
  end

  task automatic wait_taken();
    int k = 0;
    @(negedge clk);
    while (!sample_taken && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    check("taken_seen", {31'b0, sample_taken}, 32'd1);
  endtask

  task automatic capture(input int chg_bit, input logic [DW-1:0] chg_val,
                         output logic [DW-1:0] lw, output logic [DW-1:0] rw,
                         output logic zeros, output logic [1:0] lr_ok);
    logic [2*SLOT-1:0] bits;
    logic [2*SLOT-1:0] lr;
    wait_taken();
    for (int b = 0; b < 2 * SLOT; b++) begin
      bits[b] = aud_dacdat;
      lr[b]   = aud_daclrck;
      if (b == chg_bit) sample_in = chg_val;
      if (b < 2 * SLOT - 1) repeat (2 * HALF) @(negedge clk);
    end
    lw = '0; rw = '0; zeros = 1'b0;
    for (int p = 0; p < SLOT; p++) begin
`ifdef I2S_LEFT_JUSTIFY_EN
      if (p <= DW - 1) begin
        lw[DW-1-p] = bits[p];
        rw[DW-1-p] = bits[SLOT+p];
      end
`else
      if (p >= 1 && p <= DW) begin
        lw[DW-p] = bits[p];
        rw[DW-p] = bits[SLOT+p];
      end
`endif
      else zeros = zeros | bits[p] | bits[SLOT+p];
    end
    lr_ok[0] = (lr[SLOT-1:0] == '0);
    lr_ok[1] = (lr[2*SLOT-1:SLOT] == '1);
  endtask

  logic [DW-1:0] lw, rw;
  logic          zeros;
  logic [1:0]    lr_ok;
  int            ones, early;

  initial begin
    repeat (5) begin
      @(negedge clk);
      check("rst_outs", {28'b0, aud_bclk, aud_daclrck, aud_dacdat, sample_taken}, 32'd0);
    end
    reset_n = 1'b1;
    ones = 0; early = 0;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == 7)  check("bclk_t7",  {31'b0, aud_bclk}, 32'd0);
      if (k == 8)  check("bclk_t8",  {31'b0, aud_bclk}, 32'd1);
      if (k == 15) check("bclk_t15", {31'b0, aud_bclk}, 32'd1);
      if (k == 16) check("bclk_t16", {31'b0, aud_bclk}, 32'd0);
      if (k < FRAME) begin
        if (aud_dacdat) ones++;
        if (sample_taken) early++;
      end else begin
        check("first_taken_1024", {31'b0, sample_taken}, 32'd1);
      end
    end
    check("first_frame_zero", ones, 0);
    check("no_early_taken", early, 0);

    sample_in = 16'hA5C3;
    capture(-1, '0, lw, rw, zeros, lr_ok);
    check("a5c3_left",  {16'b0, lw}, 32'h0000A5C3);
    check("a5c3_right", {16'b0, rw}, 32'h0000A5C3);
    check("a5c3_pad",   {31'b0, zeros}, 32'd0);
    check("a5c3_lrck",  {30'b0, lr_ok}, 32'd3);

    sample_in = 16'h1234;
    capture(40, 16'hFFFF, lw, rw, zeros, lr_ok);
    check("mid_left",  {16'b0, lw}, 32'h00001234);
    check("mid_right", {16'b0, rw}, 32'h00001234);
    capture(-1, '0, lw, rw, zeros, lr_ok);
    check("next_left",  {16'b0, lw}, 32'h0000FFFF);
    check("next_right", {16'b0, rw}, 32'h0000FFFF);
    check("next_pad",   {31'b0, zeros}, 32'd0);

    wait_taken();
    repeat (20 * 2 * HALF) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_outs", {28'b0, aud_bclk, aud_daclrck, aud_dacdat, sample_taken}, 32'd0);
    ones = 0; early = 0;
    for (int k = 1; k < FRAME; k++) begin
      @(negedge clk);
      if (aud_dacdat) ones++;
      if (sample_taken) early++;
    end
    @(negedge clk);
    check("midrst_shadow_clear", ones, 0);
    check("midrst_no_early", early, 0);
    check("midrst_taken_1024", {31'b0, sample_taken}, 32'd1);

    sample_in = 16'h8001;
    capture(-1, '0, lw, rw, zeros, lr_ok);
    check("s8001_left",  {16'b0, lw}, 32'h00008001);
    check("s8001_right", {16'b0, rw}, 32'h00008001);
    check("s8001_pad",   {31'b0, zeros}, 32'd0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
